// File: rtl/mem_exc_unit_pkg.sv
// Shared encodings and default region table for the memory-stage exception unit.
package mem_exc_unit_pkg;

   typedef enum logic [2:0] {
      LD_NONE = 3'd0,
      LD_LW   = 3'd1,
      LD_LH   = 3'd2,
      LD_LHU  = 3'd3,
      LD_LB   = 3'd4,
      LD_LBU  = 3'd5
   } load_t;

   typedef enum logic [2:0] {
      ST_NONE = 3'd0,
      ST_SW   = 3'd1,
      ST_SH   = 3'd2,
      ST_SB   = 3'd3
   } store_t;

   localparam logic [4:0] EXC_NONE = 5'd0;
   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_ADES = 5'd5;
   localparam logic [4:0] EXC_OV   = 5'd12;

   // Region 0 = DM, 1 = Timer0, 2 = Timer1; region i lives at bits [32*i +: 32].
   localparam int unsigned DEF_N_REG = 3;

   localparam logic [DEF_N_REG*32-1:0] DEF_REG_BASE =
      {32'h0000_7F10, 32'h0000_7F00, 32'h0000_0000};
   localparam logic [DEF_N_REG*32-1:0] DEF_REG_END =
      {32'h0000_7F1B, 32'h0000_7F0B, 32'h0000_3FFF};
   localparam logic [DEF_N_REG-1:0]    DEF_WORD_ONLY = 3'b110;

   // Timer count registers are read-only; DM has an empty window (end < base).
   localparam logic [DEF_N_REG*32-1:0] DEF_RO_BASE =
      {32'h0000_7F18, 32'h0000_7F08, 32'h0000_0001};
   localparam logic [DEF_N_REG*32-1:0] DEF_RO_END =
      {32'h0000_7F1B, 32'h0000_7F0B, 32'h0000_0000};

endpackage

// File: rtl/mem_exc_unit_region_match.sv
// Combinational lookup of an address against the region table.
import mem_exc_unit_pkg::*;

module region_match #(
   parameter int unsigned             N_REG         = DEF_N_REG,
   parameter logic [N_REG*32-1:0]     REG_BASE      = DEF_REG_BASE,
   parameter logic [N_REG*32-1:0]     REG_END       = DEF_REG_END,
   parameter logic [N_REG-1:0]        REG_WORD_ONLY = DEF_WORD_ONLY,
   parameter logic [N_REG*32-1:0]     RO_BASE       = DEF_RO_BASE,
   parameter logic [N_REG*32-1:0]     RO_END        = DEF_RO_END
) (
   input  logic [31:0] addr,
   input  logic        sub_word,
   input  logic        write,
   output logic        hit,
   output logic        word_only,
   output logic        ro
);

   // Scan from the highest index down so the lowest matching region wins.
   always_comb begin
      hit       = 1'b0;
      word_only = 1'b0;
      ro        = 1'b0;
      for (int unsigned i = N_REG; i > 0; i--) begin
         if (addr >= REG_BASE[32*(i-1) +: 32] && addr <= REG_END[32*(i-1) +: 32]) begin
            hit       = 1'b1;
            word_only = REG_WORD_ONLY[i-1] & sub_word;
            ro        = write && (addr >= RO_BASE[32*(i-1) +: 32])
                              && (addr <= RO_END[32*(i-1) +: 32]);
         end
      end
   end

endmodule

// File: rtl/mem_exc_unit.sv
// Memory-stage exception unit: E->M register, region checks, exception capture.
import mem_exc_unit_pkg::*;

module mem_exc_unit #(
   parameter int unsigned             N_REG         = DEF_N_REG,
   parameter logic [N_REG*32-1:0]     REG_BASE      = DEF_REG_BASE,
   parameter logic [N_REG*32-1:0]     REG_END       = DEF_REG_END,
   parameter logic [N_REG-1:0]        REG_WORD_ONLY = DEF_WORD_ONLY,
   parameter logic [N_REG*32-1:0]     RO_BASE       = DEF_RO_BASE,
   parameter logic [N_REG*32-1:0]     RO_END        = DEF_RO_END
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        stall,
   input  logic        flush,
   input  logic [2:0]  e_load,
   input  logic [2:0]  e_store,
   input  logic [31:0] e_addr,
   input  logic [4:0]  e_exc,
   input  logic [31:0] e_pc,
   input  logic        e_bd,
   output logic [4:0]  m_exc,
   output logic        m_mem_ok,
   output logic        exc_req,
   output logic [4:0]  exc_code,
   output logic [31:0] exc_epc,
   output logic [31:0] exc_badvaddr,
   output logic        exc_bd,
   output logic        exc_lost,
   input  logic        exc_ack
);

   logic [2:0]  m_load;
   logic [2:0]  m_store;
   logic [31:0] m_addr;
   logic [4:0]  m_exc_in;
   logic [31:0] m_pc;
   logic        m_bd;

   logic        is_ld;
   logic        is_st;
   logic        sub_word;
   logic        align_fault;
   logic        rm_hit;
   logic        rm_word_only;
   logic        rm_ro;
   logic        mem_fault;
   logic        cap_fire;

   // E->M pipeline register; flush inserts a bubble and overrides stall.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_load   <= '0;
         m_store  <= '0;
         m_addr   <= '0;
         m_exc_in <= '0;
         m_pc     <= '0;
         m_bd     <= 1'b0;
      end else if (flush) begin
         m_load   <= '0;
         m_store  <= '0;
         m_addr   <= '0;
         m_exc_in <= '0;
         m_pc     <= '0;
         m_bd     <= 1'b0;
      end else if (!stall) begin
         m_load   <= e_load;
         m_store  <= e_store;
         m_addr   <= e_addr;
         m_exc_in <= e_exc;
         m_pc     <= e_pc;
         m_bd     <= e_bd;
      end
   end

   region_match #(
      .N_REG         (N_REG),
      .REG_BASE      (REG_BASE),
      .REG_END       (REG_END),
      .REG_WORD_ONLY (REG_WORD_ONLY),
      .RO_BASE       (RO_BASE),
      .RO_END        (RO_END)
   ) u_region_match (
      .addr      (m_addr),
      .sub_word  (sub_word),
      .write     (is_st),
      .hit       (rm_hit),
      .word_only (rm_word_only),
      .ro        (rm_ro)
   );

   // Access classification, alignment and merge with the upstream ExcCode.
   always_comb begin
      is_ld       = (m_load != LD_NONE);
      is_st       = !is_ld && (m_store != ST_NONE);
      sub_word    = 1'b0;
      align_fault = 1'b0;
      if (is_ld) begin
         sub_word    = (m_load != LD_LW);
         align_fault = ((m_load == LD_LW) && (m_addr[1:0] != 2'b00))
                    || ((m_load inside {LD_LH, LD_LHU}) && m_addr[0]);
      end else if (is_st) begin
         sub_word    = (m_store != ST_SW);
         align_fault = ((m_store == ST_SW) && (m_addr[1:0] != 2'b00))
                    || ((m_store == ST_SH) && m_addr[0]);
      end
      mem_fault = (is_ld || is_st)
               && (align_fault || rm_word_only || (m_exc_in == EXC_OV) || !rm_hit || rm_ro);
      if (mem_fault)
         m_exc = is_ld ? EXC_ADEL : EXC_ADES;
      else
         m_exc = m_exc_in;
      m_mem_ok = (is_ld || is_st) && (m_exc == EXC_NONE);
      cap_fire = (m_exc != EXC_NONE) && !stall;
   end

   // First-exception capture with req/ack handshake and sticky lost flag.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         exc_req      <= 1'b0;
         exc_code     <= '0;
         exc_epc      <= '0;
         exc_badvaddr <= '0;
         exc_bd       <= 1'b0;
         exc_lost     <= 1'b0;
      end else begin
         if (cap_fire && (!exc_req || exc_ack)) begin
            exc_req      <= 1'b1;
            exc_code     <= m_exc;
            exc_epc      <= m_pc;
            exc_badvaddr <= mem_fault ? m_addr : '0;
            exc_bd       <= m_bd;
         end else if (exc_ack) begin
            exc_req <= 1'b0;
         end
         // A drop needs ack low, so it can never coincide with an ack clear.
         if (cap_fire && exc_req && !exc_ack)
            exc_lost <= 1'b1;
         else if (exc_ack)
            exc_lost <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mem_exc_unit.sv
// Scoreboard bench for mem_exc_unit: a reference model predicts every output per cycle.
module tb_mem_exc_unit;

   logic        clk;
   logic        reset_n;
   logic        stall;
   logic        flush;
   logic [2:0]  e_load;
   logic [2:0]  e_store;
   logic [31:0] e_addr;
   logic [4:0]  e_exc;
   logic [31:0] e_pc;
   logic        e_bd;
   logic [4:0]  m_exc;
   logic        m_mem_ok;
   logic        exc_req;
   logic [4:0]  exc_code;
   logic [31:0] exc_epc;
   logic [31:0] exc_badvaddr;
   logic        exc_bd;
   logic        exc_lost;
   logic        exc_ack;

   int n_pass  = 0;
   int n_total = 0;

   typedef struct {
      logic [4:0]  m_exc;
      logic        mem_ok;
      logic        req;
      logic [4:0]  code;
      logic [31:0] epc;
      logic [31:0] bad;
      logic        bd;
      logic        lost;
   } exp_t;

   exp_t sb_q[$];

   // reference model state
   logic [2:0]  mm_load, mm_store;
   logic [31:0] mm_addr, mm_pc;
   logic [4:0]  mm_exc;
   logic        mm_bd;
   logic        q_req, q_bd, q_lost;
   logic [4:0]  q_code;
   logic [31:0] q_epc, q_bad;

   mem_exc_unit dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .stall        (stall),
      .flush        (flush),
      .e_load       (e_load),
      .e_store      (e_store),
      .e_addr       (e_addr),
      .e_exc        (e_exc),
      .e_pc         (e_pc),
      .e_bd         (e_bd),
      .m_exc        (m_exc),
      .m_mem_ok     (m_mem_ok),
      .exc_req      (exc_req),
      .exc_code     (exc_code),
      .exc_epc      (exc_epc),
      .exc_badvaddr (exc_badvaddr),
      .exc_bd       (exc_bd),
      .exc_lost     (exc_lost),
      .exc_ack      (exc_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
   endtask

   // {from_mem_check, code}: default table DM 0..3FFF, T0 7F00..7F0B (RO 7F08..), T1 7F10..7F1B (RO 7F18..)
   function automatic logic [5:0] ref_exc(input logic [2:0] ld, input logic [2:0] st,
                                          input logic [31:0] a, input logic [4:0] ex);
      int  r;
      logic bad;
      r = -1;
      if (a <= 32'h0000_3FFF) r = 0;
      else if (a >= 32'h0000_7F00 && a <= 32'h0000_7F0B) r = 1;
      else if (a >= 32'h0000_7F10 && a <= 32'h0000_7F1B) r = 2;
      if (ld != 3'd0) begin
         bad = (ld == 3'd1 && a[1:0] != 2'b00) || ((ld == 3'd2 || ld == 3'd3) && a[0])
            || (ld != 3'd1 && r > 0) || (ex == 5'd12) || (r < 0);
         return bad ? {1'b1, 5'd4} : {1'b0, ex};
      end else if (st != 3'd0) begin
         bad = (st == 3'd1 && a[1:0] != 2'b00) || (st == 3'd2 && a[0])
            || (st != 3'd1 && r > 0) || (ex == 5'd12) || (r < 0)
            || (r == 1 && a >= 32'h0000_7F08) || (r == 2 && a >= 32'h0000_7F18);
         return bad ? {1'b1, 5'd5} : {1'b0, ex};
      end
      return {1'b0, ex};
   endfunction

   task automatic model_reset();
      mm_load = '0; mm_store = '0; mm_addr = '0; mm_pc = '0; mm_exc = '0; mm_bd = 1'b0;
      q_req = 1'b0; q_bd = 1'b0; q_lost = 1'b0; q_code = '0; q_epc = '0; q_bad = '0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, ".m_exc"}, {27'd0, m_exc}, 32'd0);
      chk({tag, ".m_mem_ok"}, {31'd0, m_mem_ok}, 32'd0);
      chk({tag, ".exc_req"}, {31'd0, exc_req}, 32'd0);
      chk({tag, ".exc_code"}, {27'd0, exc_code}, 32'd0);
      chk({tag, ".exc_epc"}, exc_epc, 32'd0);
      chk({tag, ".exc_badvaddr"}, exc_badvaddr, 32'd0);
      chk({tag, ".exc_bd"}, {31'd0, exc_bd}, 32'd0);
      chk({tag, ".exc_lost"}, {31'd0, exc_lost}, 32'd0);
   endtask

   // Drive one cycle of stimulus, push the predicted post-edge outputs, then compare.
   task automatic step(input string tag, input logic [2:0] ld, input logic [2:0] st,
                       input logic [31:0] a, input logic [4:0] ex, input logic [31:0] pc,
                       input logic bd, input logic stl, input logic fl, input logic ak);
      logic [5:0] cur, nxt;
      logic cap, drop;
      exp_t e, g;
      e_load = ld; e_store = st; e_addr = a; e_exc = ex; e_pc = pc; e_bd = bd;
      stall = stl; flush = fl; exc_ack = ak;

      cur  = ref_exc(mm_load, mm_store, mm_addr, mm_exc);
      cap  = (cur[4:0] != 5'd0) && !stl;
      drop = cap && q_req && !ak;
      if (cap && (!q_req || ak)) begin
         q_req = 1'b1; q_code = cur[4:0]; q_epc = mm_pc; q_bd = mm_bd;
         q_bad = cur[5] ? mm_addr : 32'd0;
      end else if (ak) q_req = 1'b0;
      if (drop) q_lost = 1'b1;
      else if (ak) q_lost = 1'b0;

      if (fl) begin
         mm_load = '0; mm_store = '0; mm_addr = '0; mm_exc = '0; mm_pc = '0; mm_bd = 1'b0;
      end else if (!stl) begin
         mm_load = ld; mm_store = st; mm_addr = a; mm_exc = ex; mm_pc = pc; mm_bd = bd;
      end
      nxt = ref_exc(mm_load, mm_store, mm_addr, mm_exc);

      e.m_exc  = nxt[4:0];
      e.mem_ok = (mm_load != 3'd0 || mm_store != 3'd0) && (nxt[4:0] == 5'd0);
      e.req = q_req; e.code = q_code; e.epc = q_epc; e.bad = q_bad; e.bd = q_bd; e.lost = q_lost;
      sb_q.push_back(e);

      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
         chk({tag, ".sb_empty"}, 32'd1, 32'd0);
      end else begin
         g = sb_q.pop_front();
         chk({tag, ".m_exc"}, {27'd0, m_exc}, {27'd0, g.m_exc});
         chk({tag, ".m_mem_ok"}, {31'd0, m_mem_ok}, {31'd0, g.mem_ok});
         chk({tag, ".exc_req"}, {31'd0, exc_req}, {31'd0, g.req});
         if (g.req) begin
            chk({tag, ".exc_code"}, {27'd0, exc_code}, {27'd0, g.code});
            chk({tag, ".exc_epc"}, exc_epc, g.epc);
            chk({tag, ".exc_badvaddr"}, exc_badvaddr, g.bad);
            chk({tag, ".exc_bd"}, {31'd0, exc_bd}, {31'd0, g.bd});
         end
         chk({tag, ".exc_lost"}, {31'd0, exc_lost}, {31'd0, g.lost});
      end
   endtask

   task automatic nop(input string tag, input logic ak);
      step(tag, 3'd0, 3'd0, 32'd0, 5'd0, 32'h0000_1000, 1'b0, 1'b0, 1'b0, ak);
   endtask

   localparam int unsigned N_POOL = 12;
   logic [31:0] addr_pool [N_POOL] = '{32'h0000_0000, 32'h0000_3002, 32'h0000_3FFE, 32'h0000_3FFF,
                                       32'h0000_4000, 32'h0000_7F00, 32'h0000_7F08, 32'h0000_7F0A,
                                       32'h0000_7F0C, 32'h0000_7F14, 32'h0000_7F18, 32'h8000_0000};
   logic [4:0]  exc_pool [4] = '{5'd0, 5'd0, 5'd12, 5'd10};

   initial begin
      int unsigned op;
      logic [2:0] rl, rs;
      reset_n = 1'b1;
      stall = 1'b0; flush = 1'b0; exc_ack = 1'b0;
      e_load = '0; e_store = '0; e_addr = '0; e_exc = '0; e_pc = '0; e_bd = 1'b0;
      model_reset();
      #1 reset_n = 1'b0;
      #2 chk_all_zero("reset");
      repeat (2) @(posedge clk);
      @(negedge clk) reset_n = 1'b1;

      // misaligned LW in DM, then capture
      step("lw_misalign", 3'd1, 3'd0, 32'h0000_3002, 5'd0, 32'h0000_3000, 1'b1, 1'b0, 1'b0, 1'b0);
      nop("lw_misalign_cap", 1'b0);
      nop("ack1", 1'b1);

      // timer checks
      step("sb_t0", 3'd0, 3'd3, 32'h0000_7F00, 5'd0, 32'h0000_3010, 1'b0, 1'b0, 1'b0, 1'b0);
      step("sw_t0_ro", 3'd0, 3'd1, 32'h0000_7F08, 5'd0, 32'h0000_3014, 1'b0, 1'b0, 1'b0, 1'b1);
      step("lw_t0_ro", 3'd1, 3'd0, 32'h0000_7F08, 5'd0, 32'h0000_3018, 1'b0, 1'b0, 1'b0, 1'b1);
      nop("ack2", 1'b1);
      nop("ack3", 1'b1);

      // overflow merging
      step("sw_ov", 3'd0, 3'd1, 32'h0000_0100, 5'd12, 32'h0000_3020, 1'b0, 1'b0, 1'b0, 1'b0);
      nop("sw_ov_cap", 1'b1);
      step("nomem_ov", 3'd0, 3'd0, 32'h0000_0104, 5'd12, 32'h0000_3024, 1'b1, 1'b0, 1'b0, 1'b1);
      nop("nomem_ov_cap", 1'b0);
      nop("ack4", 1'b1);

      // lost-exception path
      step("miss1", 3'd1, 3'd0, 32'h8000_0000, 5'd0, 32'h0000_3030, 1'b0, 1'b0, 1'b0, 1'b0);
      step("miss2", 3'd1, 3'd0, 32'h8000_0000, 5'd0, 32'h0000_3034, 1'b0, 1'b0, 1'b0, 1'b0);
      step("miss3", 3'd1, 3'd0, 32'h8000_0000, 5'd0, 32'h0000_3038, 1'b0, 1'b0, 1'b0, 1'b0);
      step("miss3_ack", 3'd0, 3'd0, 32'd0, 5'd0, 32'h0000_303C, 1'b0, 1'b0, 1'b0, 1'b1);
      nop("ack5", 1'b1);

      // flush and stall
      step("flush_adel", 3'd1, 3'd0, 32'h0000_0001, 5'd0, 32'h0000_3040, 1'b0, 1'b0, 1'b1, 1'b0);
      nop("flush_after", 1'b0);
      for (int i = 0; i < 3; i++)
         step("stall_adel", 3'd2, 3'd0, 32'h0000_0003, 5'd0, 32'h0000_3044, 1'b0, 1'b1, 1'b0, 1'b0);
      step("stall_rel", 3'd2, 3'd0, 32'h0000_0003, 5'd0, 32'h0000_3044, 1'b0, 1'b0, 1'b0, 1'b0);
      nop("stall_cap", 1'b0);
      nop("stall_once", 1'b0);
      nop("ack6", 1'b1);

      // boundaries
      step("lb_dm_top", 3'd4, 3'd0, 32'h0000_3FFF, 5'd0, 32'h0000_3050, 1'b0, 1'b0, 1'b0, 1'b0);
      step("lb_dm_past", 3'd5, 3'd0, 32'h0000_4000, 5'd0, 32'h0000_3054, 1'b0, 1'b0, 1'b0, 1'b0);
      step("lhu_t1", 3'd3, 3'd0, 32'h0000_7F10, 5'd0, 32'h0000_3058, 1'b0, 1'b0, 1'b0, 1'b1);
      step("sw_t1_ok", 3'd0, 3'd1, 32'h0000_7F14, 5'd0, 32'h0000_305C, 1'b0, 1'b0, 1'b0, 1'b1);
      step("sw_gap", 3'd0, 3'd1, 32'h0000_7F0C, 5'd0, 32'h0000_3060, 1'b0, 1'b0, 1'b0, 1'b1);
      nop("ack7", 1'b1);

      // randomised traffic
      for (int i = 0; i < 40; i++) begin
         op = $urandom_range(0, 8);
         rl = (op >= 1 && op <= 5) ? 3'(op) : 3'd0;
         rs = (op >= 6) ? 3'(op - 5) : 3'd0;
         step("rand", rl, rs, addr_pool[$urandom_range(0, N_POOL - 1)],
              exc_pool[$urandom_range(0, 3)], 32'h0000_4000 + 32'(i * 4), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 7) == 0),
              1'($urandom_range(0, 2) == 0));
      end

      // reset in the middle of a pending handshake
      step("pre_rst", 3'd1, 3'd0, 32'h0000_0002, 5'd0, 32'h0000_5000, 1'b1, 1'b0, 1'b0, 1'b0);
      nop("pre_rst_cap", 1'b0);
      chk("pre_rst.req", {31'd0, exc_req}, 32'd1);
      #1 reset_n = 1'b0;
      #1 chk_all_zero("async_rst");
      model_reset();
      @(negedge clk) reset_n = 1'b1;
      nop("post_rst", 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
